branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 9 +
 rtl/branch_resolver_if.sv | 25 ++
 rtl/branch_resolver_pred_fifo.sv | 39 +++
 rtl/branch_resolver.sv | 57 +++++
 tb/tb_branch_resolver.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared constants, state encoding and prediction record layout
package branch_resolver_pkg;
  localparam logic [15:0] NO_PRED = 16'hFFFF;
  typedef enum logic {RUN, FLUSH} stateT;
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] addr;
  } recT;
endpackage

// File: rtl/branch_resolver_if.sv
// branch_resolver_if: fetch push, execute resolution and predictor/flush outputs
interface branch_resolver_if;
  logic        predValid;
  logic [15:0] predPC;
  logic [15:0] predAddr;
  logic        stall;
  logic        resValid;
  logic [15:0] resPC;
  logic        resTaken;
  logic [15:0] resTarget;
  logic        branch;
  logic [15:0] branchPC;
  logic [15:0] branchAddr;
  logic        flush;
  logic [15:0] redirectPC;
  logic [15:0] mispredCount;
  modport master(
    output predValid, predPC, predAddr, resValid, resPC, resTaken, resTarget,
    input  stall, branch, branchPC, branchAddr, flush, redirectPC, mispredCount
  );
  modport slave(
    input  predValid, predPC, predAddr, resValid, resPC, resTaken, resTarget,
    output stall, branch, branchPC, branchAddr, flush, redirectPC, mispredCount
  );
endinterface

// File: rtl/branch_resolver_pred_fifo.sv
// pred_fifo: DEPTH-entry record queue; push while full is dropped even with a pop
module pred_fifo import branch_resolver_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  recT  din,
  output logic full,
  output logic empty,
  output recT  head
);
  localparam int AW = $clog2(DEPTH);
  recT mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic doPush, doPop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign head = mem[rdPtr];
  // storage needs no reset; count and pointers define what is valid
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr] <= din;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: matches resolved branches against queued predictions, trains predictor, flushes on mispredict
module branch_resolver import branch_resolver_pkg::*; #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  branch_resolver_if.slave bus
);
  stateT state, nextState;
  recT head;
  logic full, empty, run, doPush, doRes, pcMatch, correct, mispred;
  logic [15:0] predA;
  assign run = state == RUN;
  assign doPush = bus.predValid && !full && run;
  assign doRes = bus.resValid && run;
  assign predA = empty ? NO_PRED : head.addr;
  assign pcMatch = empty || head.pc == bus.resPC;
  assign correct = pcMatch && ((predA != NO_PRED && bus.resTaken && bus.resTarget == predA) ||
                               (predA == NO_PRED && !bus.resTaken));
  assign mispred = doRes && !correct;
  assign bus.stall = full;
  pred_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(doPush),
    .pop(doRes && !empty),
    .clear(state == FLUSH),
    .din(recT'({bus.predPC, bus.predAddr})),
    .full(full),
    .empty(empty),
    .head(head)
  );
  // state register
  always_ff @(posedge clk)
    state <= reset ? RUN : nextState;
  // FLUSH lasts exactly one cycle
  always_comb nextState = (run && mispred) ? FLUSH : RUN;
  // registered predictor update, flush strobe and saturating mispredict counter
  always_ff @(posedge clk)
    if (reset) begin
      bus.branch <= 1'b0;
      bus.branchPC <= '0;
      bus.branchAddr <= '0;
      bus.flush <= 1'b0;
      bus.redirectPC <= '0;
      bus.mispredCount <= '0;
    end else begin
      bus.branch <= doRes && bus.resTaken;
      if (doRes && bus.resTaken) begin
        bus.branchPC <= bus.resPC;
        bus.branchAddr <= bus.resTarget;
      end
      bus.flush <= mispred;
      if (mispred) bus.redirectPC <= bus.resTaken ? bus.resTarget : bus.resPC + 16'd1;
      if (mispred && bus.mispredCount != 16'hFFFF) bus.mispredCount <= bus.mispredCount + 16'd1;
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors with a strobe scoreboard for branch_resolver
module tb_branch_resolver;
  import branch_resolver_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  branch_resolver_if bus();
  branch_resolver #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic br;
    logic [15:0] bpc;
    logic [15:0] baddr;
    logic fl;
    logic [15:0] rpc;
  } expT;
  expT expQ[$];
  expT mon;
  int nChecks = 0;
  int nFails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  task automatic expect_out(input logic br, input logic [15:0] bpc, baddr, input logic fl, input logic [15:0] rpc);
    expQ.push_back('{br, bpc, baddr, fl, rpc});
  endtask
  task automatic cyc(input logic pv, input logic [15:0] ppc, pa,
                     input logic rv, input logic [15:0] rpc, input logic rt, input logic [15:0] rtg);
    bus.predValid = pv;
    bus.predPC = ppc;
    bus.predAddr = pa;
    bus.resValid = rv;
    bus.resPC = rpc;
    bus.resTaken = rt;
    bus.resTarget = rtg;
    @(posedge clk);
    #1;
    bus.predValid = 1'b0;
    bus.resValid = 1'b0;
  endtask
  task automatic push(input logic [15:0] pc, a);
    cyc(1'b1, pc, a, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask
  task automatic resolve(input logic [15:0] pc, input logic t, input logic [15:0] tg);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, pc, t, tg);
  endtask
  task automatic idle();
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask
  // monitor: every strobe must match the oldest expected response
  always @(negedge clk)
    if (bus.branch || bus.flush) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_strobe: got branch=%b flush=%b want none", bus.branch, bus.flush);
      end else begin
        mon = expQ.pop_front();
        check("branch", 32'(bus.branch), 32'(mon.br));
        check("flush", 32'(bus.flush), 32'(mon.fl));
        if (mon.br) check("branchPC", 32'(bus.branchPC), 32'(mon.bpc));
        if (mon.br) check("branchAddr", 32'(bus.branchAddr), 32'(mon.baddr));
        if (mon.fl) check("redirectPC", 32'(bus.redirectPC), 32'(mon.rpc));
      end
    end
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    bus.predValid = 1'b0;
    bus.predPC = '0;
    bus.predAddr = '0;
    bus.resValid = 1'b0;
    bus.resPC = '0;
    bus.resTaken = 1'b0;
    bus.resTarget = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_branch", 32'(bus.branch), 0);
    check("rst_flush", 32'(bus.flush), 0);
    check("rst_branchPC", 32'(bus.branchPC), 0);
    check("rst_branchAddr", 32'(bus.branchAddr), 0);
    check("rst_redirectPC", 32'(bus.redirectPC), 0);
    check("rst_mispredCount", 32'(bus.mispredCount), 0);
    push(16'h0010, 16'h0040);
    expect_out(1'b1, 16'h0010, 16'h0040, 1'b0, 16'h0);
    resolve(16'h0010, 1'b1, 16'h0040);
    check("correct_count", 32'(bus.mispredCount), 0);
    push(16'h0020, NO_PRED);
    push(16'h0024, 16'h0060);
    expect_out(1'b1, 16'h0020, 16'h0100, 1'b1, 16'h0100);
    resolve(16'h0020, 1'b1, 16'h0100);
    check("mispred_count1", 32'(bus.mispredCount), 1);
    push(16'h0030, 16'h0050);
    expect_out(1'b1, 16'h0024, 16'h0060, 1'b1, 16'h0060);
    resolve(16'h0024, 1'b1, 16'h0060);
    check("cleared_count2", 32'(bus.mispredCount), 2);
    idle();
    check("cleared_stall", 32'(bus.stall), 0);
    push(16'hFFFF, 16'h0008);
    expect_out(1'b0, 16'h0, 16'h0, 1'b1, 16'h0000);
    resolve(16'hFFFF, 1'b0, 16'h0);
    check("wrap_count3", 32'(bus.mispredCount), 3);
    idle();
    resolve(16'h0040, 1'b0, 16'h0);
    check("empty_nt_branch", 32'(bus.branch), 0);
    check("empty_nt_flush", 32'(bus.flush), 0);
    expect_out(1'b1, 16'h0044, 16'h0200, 1'b1, 16'h0200);
    resolve(16'h0044, 1'b1, 16'h0200);
    check("empty_t_count4", 32'(bus.mispredCount), 4);
    idle();
    for (int i = 0; i < 4; i++) begin
      check("stall_filling", 32'(bus.stall), 0);
      push(16'h0100 + 16'(2 * i), 16'h0110 + 16'(2 * i));
    end
    check("stall_full", 32'(bus.stall), 1);
    push(16'h0108, 16'h0118);
    check("stall_drop", 32'(bus.stall), 1);
    expect_out(1'b1, 16'h0100, 16'h0110, 1'b0, 16'h0);
    cyc(1'b1, 16'h010A, 16'h011A, 1'b1, 16'h0100, 1'b1, 16'h0110);
    check("stall_pushpop", 32'(bus.stall), 0);
    push(16'h010C, 16'h011C);
    check("stall_refull", 32'(bus.stall), 1);
    for (int i = 1; i < 4; i++) begin
      expect_out(1'b1, 16'h0100 + 16'(2 * i), 16'h0110 + 16'(2 * i), 1'b0, 16'h0);
      resolve(16'h0100 + 16'(2 * i), 1'b1, 16'h0110 + 16'(2 * i));
    end
    expect_out(1'b1, 16'h010C, 16'h011C, 1'b0, 16'h0);
    resolve(16'h010C, 1'b1, 16'h011C);
    check("drain_stall", 32'(bus.stall), 0);
    check("drain_count4", 32'(bus.mispredCount), 4);
    push(16'h0200, 16'h0300);
    expect_out(1'b0, 16'h0, 16'h0, 1'b1, 16'h0201);
    resolve(16'h0200, 1'b0, 16'h0);
    reset = 1'b1;
    push(16'h0210, 16'h0220);
    reset = 1'b0;
    check("flushrst_branch", 32'(bus.branch), 0);
    check("flushrst_flush", 32'(bus.flush), 0);
    check("flushrst_stall", 32'(bus.stall), 0);
    check("flushrst_count", 32'(bus.mispredCount), 0);
    check("flushrst_branchPC", 32'(bus.branchPC), 0);
    check("flushrst_branchAddr", 32'(bus.branchAddr), 0);
    check("flushrst_redirectPC", 32'(bus.redirectPC), 0);
    resolve(16'h0210, 1'b0, 16'h0);
    check("postrst_flush", 32'(bus.flush), 0);
    check("postrst_count", 32'(bus.mispredCount), 0);
    idle();
    idle();
    check("scoreboard_drained", 32'(expQ.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
